// File: rtl/bp_pkg.sv
// Shared constants, FSM state type and LLR magnitude helper for the
// belief-propagation check-node datapath.
package bp_pkg;

  localparam int N_COLS = 6;
  localparam int LLR_W  = 8;
  localparam int IDX_W  = 3;
  localparam int MAG_W  = LLR_W - 1;

  localparam logic [MAG_W-1:0] LLR_MAX = {MAG_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Magnitude of a two's-complement LLR; the most negative code saturates to LLR_MAX
  // so every magnitude fits in LLR_W-1 bits and its negation never overflows.
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [LLR_W-1:0] x);
    logic signed [LLR_W-1:0] neg;
    neg = -x;
    if (x == {1'b1, {MAG_W{1'b0}}})
      return LLR_MAX;
    else if (x[LLR_W-1])
      return neg[MAG_W-1:0];
    else
      return x[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/bp_two_min_tracker.sv
// Running two-smallest-magnitude tracker with index of the smallest.
// Outputs already include the sample presented this cycle (when enabled).
module bp_two_min_tracker
  import bp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [MAG_W-1:0] value,
  input  logic [IDX_W-1:0] index,
  output logic [MAG_W-1:0] min1,
  output logic [MAG_W-1:0] min2,
  output logic [IDX_W-1:0] idx1
);

  logic [MAG_W-1:0] min1_q;
  logic [MAG_W-1:0] min2_q;
  logic [IDX_W-1:0] idx1_q;

  // Strict less-than keeps the earliest index on ties.
  always_comb begin
    min1 = min1_q;
    min2 = min2_q;
    idx1 = idx1_q;
    if (enable) begin
      if (value < min1_q) begin
        min2 = min1_q;
        min1 = value;
        idx1 = index;
      end else if (value < min2_q) begin
        min2 = value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1_q <= LLR_MAX;
      min2_q <= LLR_MAX;
      idx1_q <= '0;
    end else if (clear) begin
      min1_q <= LLR_MAX;
      min2_q <= LLR_MAX;
      idx1_q <= '0;
    end else begin
      min1_q <= min1;
      min2_q <= min2;
      idx1_q <= idx1;
    end
  end

endmodule

// File: rtl/bp_row_processor.sv
// Min-sum check-node row processor: scans one row's V2C LLRs, then writes
// the C2V messages back column by column and raises a level done.
module bp_row_processor
  import bp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N_COLS-1:0]       row_mask,
  output logic [IDX_W-1:0]        col_addr,
  input  logic signed [LLR_W-1:0] v2c_llr,
  output logic                    msg_we,
  output logic [IDX_W-1:0]        msg_addr,
  output logic signed [LLR_W-1:0] msg_data,
  output logic                    busy,
  output logic                    done
);

  function automatic logic signed [LLR_W-1:0] apply_sign(input logic s,
                                                         input logic [MAG_W-1:0] m);
    logic signed [LLR_W-1:0] mx;
    mx = {1'b0, m};
    return s ? -mx : mx;
  endfunction

  state_t              state;
  logic [IDX_W-1:0]    j;
  logic [N_COLS-1:0]   mask_q;
  logic [N_COLS-1:0]   signs_q;
  logic                sgn_q;

  logic                start_acc;
  logic                scan_en;
  logic                last;
  logic                sgn_nxt;
  logic [MAG_W-1:0]    mag;
  logic [MAG_W-1:0]    min1;
  logic [MAG_W-1:0]    min2;
  logic [IDX_W-1:0]    idx1;

  logic                wr_load_p0;
  logic [IDX_W-1:0]    wr_col_p0;
  logic [MAG_W-1:0]    wr_mag_p0;
  logic signed [LLR_W-1:0] wr_data_p0;

  assign start_acc = start && (state == IDLE || state == DONE);
  assign scan_en   = (state == SCAN) && mask_q[j];
  assign last      = (j == IDX_W'(N_COLS - 1));
  assign mag       = abs_sat(v2c_llr);
  assign sgn_nxt   = sgn_q ^ (scan_en & v2c_llr[LLR_W-1]);
  assign col_addr  = j;

  bp_two_min_tracker u_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_acc),
    .enable (scan_en),
    .value  (mag),
    .index  (j),
    .min1   (min1),
    .min2   (min2),
    .idx1   (idx1)
  );

  // Message for column wr_col is formed one cycle ahead so that the registered
  // write appears in WRITE cycle j; column 0 is formed on the final SCAN cycle
  // from the tracker's look-through outputs, which already include column N_COLS-1.
  always_comb begin
    wr_load_p0 = ((state == SCAN) && last) || ((state == WRITE) && !last);
    wr_col_p0  = (state == SCAN) ? '0 : j + IDX_W'(1);
    wr_mag_p0  = (wr_col_p0 == idx1) ? min2 : min1;
    wr_data_p0 = apply_sign(sgn_nxt ^ signs_q[wr_col_p0], wr_mag_p0);
  end

  // ---- stage p1: registered FSM and write port ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      j        <= '0;
      mask_q   <= '0;
      signs_q  <= '0;
      sgn_q    <= 1'b0;
      msg_we   <= 1'b0;
      msg_addr <= '0;
      msg_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (wr_load_p0) begin
        msg_we   <= mask_q[wr_col_p0];
        msg_addr <= wr_col_p0;
        msg_data <= wr_data_p0;
      end else begin
        msg_we   <= 1'b0;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            mask_q  <= row_mask;
            signs_q <= '0;
            sgn_q   <= 1'b0;
            j       <= '0;
            state   <= SCAN;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        SCAN: begin
          sgn_q <= sgn_nxt;
          if (scan_en) signs_q[j] <= v2c_llr[LLR_W-1];
          if (last) begin
            j     <= '0;
            state <= WRITE;
          end else begin
            j <= j + IDX_W'(1);
          end
        end
        WRITE: begin
          if (last) begin
            j     <= '0;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            j <= j + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
